// File: rtl/test_half_adder.sv
// Bit-parallel half adder with a registered result path and saturating statistics counters.
// Optional registered parity output enabled by defining HA_PARITY_EN.
module test_half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Carry,
    input  logic             in_valid,
    input  logic             cnt_clear,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] op_cnt,
    output logic             parity_q
);

    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_cc_sum;
    logic [CNT_W-1:0] w_cc_next;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic             r_valid;
    logic [CNT_W-1:0] r_carry_cnt;
    logic [CNT_W-1:0] r_op_cnt;

    assign w_sum   = A ^ B;
    assign w_carry = A & B;
    assign Sum     = w_sum;
    assign Carry   = w_carry;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PW'(w_carry[i]);
        end
    end

    // Widened add so an overflow is visible and can be clamped.
    assign w_cc_sum  = SW'(r_carry_cnt) + SW'(w_pop);
    assign w_cc_next = (w_cc_sum > SW'(CNT_MAX)) ? CNT_MAX
                                                 : w_cc_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_valid     <= 1'b0;
            r_carry_cnt <= '0;
            r_op_cnt    <= '0;
        end else begin
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
            r_valid <= in_valid;
            if (cnt_clear) begin
                r_carry_cnt <= '0;
                r_op_cnt    <= '0;
            end else if (in_valid) begin
                r_carry_cnt <= w_cc_next;
                if (r_op_cnt != CNT_MAX) begin
                    r_op_cnt <= r_op_cnt + 1'b1;
                end
            end
        end
    end

`ifdef HA_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (in_valid) begin
            r_parity <= ^{w_sum, w_carry};
        end
    end

    assign parity_q = r_parity;
`else
    assign parity_q = 1'b0;
`endif

    assign sum_q     = r_sum;
    assign carry_q   = r_carry;
    assign out_valid = r_valid;
    assign carry_cnt = r_carry_cnt;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_test_half_adder.sv
// Scoreboard bench for test_half_adder: a WIDTH=1/CNT_W=2 instance and a
// WIDTH=4/CNT_W=16 instance, expected results queued and checked by monitors.
module tb_test_half_adder;

    typedef struct {
        logic [3:0]  sum;
        logic [3:0]  carry;
        logic [15:0] cc;
        logic [15:0] oc;
        logic        par;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=1, CNT_W=2
    logic       rst0, v0, c0;
    logic [0:0] A0, B0, S0, C0, sq0, cq0;
    logic       ov0, p0;
    logic [1:0] cc0, oc0;

    // Instance 1: WIDTH=4, CNT_W=16
    logic        rst1, v1, c1;
    logic [3:0]  A1, B1, S1, C1, sq1, cq1;
    logic        ov1, p1;
    logic [15:0] cc1, oc1;

    test_half_adder #(.WIDTH(1), .CNT_W(2)) u0 (
        .clk(clk), .rst(rst0), .A(A0), .B(B0),
        .Sum(S0), .Carry(C0), .in_valid(v0), .cnt_clear(c0),
        .sum_q(sq0), .carry_q(cq0), .out_valid(ov0),
        .carry_cnt(cc0), .op_cnt(oc0), .parity_q(p0)
    );

    test_half_adder #(.WIDTH(4), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst1), .A(A1), .B(B1),
        .Sum(S1), .Carry(C1), .in_valid(v1), .cnt_clear(c1),
        .sum_q(sq1), .carry_q(cq1), .out_valid(ov1),
        .carry_cnt(cc1), .op_cnt(oc1), .parity_q(p1)
    );

    int m_cc0 = 0, m_oc0 = 0;
    int m_cc1 = 0, m_oc1 = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic par_exp(input logic p);
`ifdef HA_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle on instance 0; es/ec/ep are hand-computed results.
    task automatic step0(input logic a, b, v, c,
                         input logic es, ec, ep);
        int pop;
        A0 = a; B0 = b; v0 = v; c0 = c;
        pop = (a & b) ? 1 : 0;
        if (c) begin
            m_cc0 = 0; m_oc0 = 0;
        end else if (v) begin
            m_cc0 = (m_cc0 + pop > 3) ? 3 : m_cc0 + pop;
            m_oc0 = (m_oc0 + 1 > 3) ? 3 : m_oc0 + 1;
        end
        if (v) q0.push_back('{{3'b0, es}, {3'b0, ec}, 16'(m_cc0),
                              16'(m_oc0), par_exp(ep)});
        @(posedge clk); #1;
    endtask

    task automatic step1(input logic [3:0] a, b, input logic v, c,
                         input logic [3:0] es, ec, input logic ep);
        int pop;
        A1 = a; B1 = b; v1 = v; c1 = c;
        pop = $countones(ec);
        if (c) begin
            m_cc1 = 0; m_oc1 = 0;
        end else if (v) begin
            m_cc1 = m_cc1 + pop;
            m_oc1 = m_oc1 + 1;
        end
        if (v) q1.push_back('{es, ec, 16'(m_cc1), 16'(m_oc1),
                              par_exp(ep)});
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov0) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_valid", 32'(ov0), 32'h0);
            end else begin
                e = q0.pop_front();
                chk("u0_sum_q", 32'(sq0), 32'(e.sum));
                chk("u0_carry_q", 32'(cq0), 32'(e.carry));
                chk("u0_carry_cnt", 32'(cc0), 32'(e.cc));
                chk("u0_op_cnt", 32'(oc0), 32'(e.oc));
                chk("u0_parity_q", 32'(p0), 32'(e.par));
            end
        end
        if (ov1) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_valid", 32'(ov1), 32'h0);
            end else begin
                e = q1.pop_front();
                chk("u1_sum_q", 32'(sq1), 32'(e.sum));
                chk("u1_carry_q", 32'(cq1), 32'(e.carry));
                chk("u1_carry_cnt", 32'(cc1), 32'(e.cc));
                chk("u1_op_cnt", 32'(oc1), 32'(e.oc));
                chk("u1_parity_q", 32'(p1), 32'(e.par));
            end
        end
    end

    initial begin
        rst0 = 1'b1; v0 = 1'b0; c0 = 1'b0; A0 = '0; B0 = '0;
        rst1 = 1'b1; v1 = 1'b0; c1 = 1'b0; A1 = '0; B1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("u0_rst_regs", {sq0, cq0, ov0, cc0, oc0, p0}, 32'h0);
        chk("u1_rst_regs", {sq1, cq1, ov1, cc1, oc1, p1}, 32'h0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // Truth table, each vector held 20 ns
        A0 = 1'b0; B0 = 1'b0; #10;
        chk("tt_00", {S0, C0}, 32'b00); #10;
        A0 = 1'b0; B0 = 1'b1; #10;
        chk("tt_01", {S0, C0}, 32'b10); #10;
        A0 = 1'b1; B0 = 1'b0; #10;
        chk("tt_10", {S0, C0}, 32'b10); #10;
        A0 = 1'b1; B0 = 1'b1; #10;
        chk("tt_11", {S0, C0}, 32'b01); #10;
        @(posedge clk); #1;

        // Registered path: one sample then hold
        step0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("u0_valid_drop", 32'(ov0), 32'h0);
        chk("u0_hold", {sq0, cq0}, 32'b01);
        @(posedge clk); #1;

        // Saturation at 3 with CNT_W=2
        step0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        step0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_op_cnt", 32'(oc0), 32'd3);
        chk("sat_carry_cnt", 32'(cc0), 32'd3);
        @(posedge clk); #1;

        // Reset wins over in_valid; combinational path stays live
        rst0 = 1'b1;
        step0(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v0 = 1'b1;
        m_cc0 = 0; m_oc0 = 0;
        @(negedge clk);
        chk("rst_prio_regs", {sq0, cq0, ov0, cc0, oc0, p0}, 32'h0);
        chk("rst_prio_comb", {S0, C0}, 32'b01);
        @(posedge clk); #1;
        rst0 = 1'b0; v0 = 1'b0;

        // Four-lane combinational spot checks
        A1 = 4'b1100; B1 = 4'b1010; #1;
        chk("u1_comb_sum", 32'(S1), 32'h6);
        chk("u1_comb_carry", 32'(C1), 32'h8);
        @(posedge clk); #1;

        // Counters
        step1(4'b1111, 4'b1010, 1'b1, 1'b0, 4'b0101, 4'b1010, 1'b0);
        step1(4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0010, 4'b0001, 1'b0);
        step1(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("cnt_carry", 32'(cc1), 32'd3);
        chk("cnt_op", 32'(oc1), 32'd2);
        chk("cnt_hold_sum", 32'(sq1), 32'h2);
        chk("cnt_valid_drop", 32'(ov1), 32'h0);
        @(posedge clk); #1;

        // Clear together with in_valid
        step1(4'b0110, 4'b0101, 1'b1, 1'b1, 4'b0011, 4'b0100, 1'b1);
        step1(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("clr_counts", {cc1, oc1}, 32'h0);
        chk("clr_sum_q", 32'(sq1), 32'h3);
        @(posedge clk); #1;

        // Parity vectors, then back-to-back
        step1(4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0010, 4'b0001, 1'b0);
        step1(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1);
        step1(4'b1111, 4'b0111, 1'b1, 1'b0, 4'b1000, 4'b0111, 1'b0);
        step1(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("par_hold", 32'(p1), 32'(par_exp(1'b0)));
        chk("end_carry_cnt", 32'(cc1), 32'd4);
        chk("end_op_cnt", 32'(oc1), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
